// File: rtl/store_commit_queue.sv
// Store commit queue: holds translated stores speculatively until commit, then
// drains committed stores in order to the data cache over a valid/grant port.
module store_commit_queue #(
    parameter int unsigned PLEN         = 56,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned DEPTH_SPEC   = 4,
    parameter int unsigned DEPTH_COMMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              valid_without_flush_i,
    output logic              ready_o,
    input  logic [PLEN-1:0]   paddr_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic [1:0]        data_size_i,
    input  logic              commit_i,
    output logic              commit_ready_o,
    input  logic              stall_st_pending_i,
    output logic              no_st_pending_o,
    output logic              empty_o,
    input  logic [11:0]       page_offset_i,
    output logic              page_offset_matches_o,
    output logic              req_valid_o,
    input  logic              req_gnt_i,
    output logic [PLEN-1:0]   req_addr_o,
    output logic [XLEN-1:0]   req_data_o,
    output logic [XLEN/8-1:0] req_be_o,
    output logic [1:0]        req_size_o
);
    localparam int unsigned BE_W = XLEN / 8;
    localparam int unsigned SP_W = $clog2(DEPTH_SPEC);
    localparam int unsigned SC_W = SP_W + 1;
    localparam int unsigned CP_W = $clog2(DEPTH_COMMIT);
    localparam int unsigned CC_W = CP_W + 1;
    localparam logic [SC_W-1:0] SPEC_FULL   = SC_W'(DEPTH_SPEC);
    localparam logic [CC_W-1:0] COMMIT_FULL = CC_W'(DEPTH_COMMIT);

    // Address is kept doubleword-granular; the low 3 bits never leave the block.
    typedef struct packed {
        logic [PLEN-4:0] addr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
        logic [1:0]      size;
    } entry_t;

    typedef enum logic {IDLE, REQ} state_e;

    entry_t spec_mem_q   [DEPTH_SPEC];
    entry_t commit_mem_q [DEPTH_COMMIT];

    logic [SP_W-1:0] spec_wr_q, spec_wr_d, spec_rd_q, spec_rd_d;
    logic [SC_W-1:0] spec_cnt_q, spec_cnt_d;
    logic [CP_W-1:0] commit_wr_q, commit_wr_d, commit_rd_q, commit_rd_d;
    logic [CC_W-1:0] commit_cnt_q, commit_cnt_d;
    state_e          state_q, state_d;

    logic   push, commit, pop;
    entry_t in_entry, commit_head;
    logic   unused_lsbs;

    assign unused_lsbs = ^{paddr_i[2:0], page_offset_i[2:0]};

    assign in_entry    = '{addr: paddr_i[PLEN-1:3], data: data_i, be: be_i, size: data_size_i};
    assign commit_head = commit_mem_q[commit_rd_q];

    assign push   = valid_i && !flush_i && (spec_cnt_q < SPEC_FULL);
    assign commit = commit_i && commit_ready_o && (spec_cnt_q != '0) && !flush_i;
    assign pop    = (state_q == REQ) && req_gnt_i;

    assign ready_o         = (spec_cnt_q + SC_W'(valid_i)) < SPEC_FULL;
    assign commit_ready_o  = commit_cnt_q < COMMIT_FULL;
    assign empty_o         = (spec_cnt_q == '0) && (commit_cnt_q == '0);
    assign no_st_pending_o = (commit_cnt_q == '0) && (state_q == IDLE);
    assign req_valid_o     = (state_q == REQ);
    assign req_addr_o      = {commit_head.addr, 3'b000};
    assign req_data_o      = commit_head.data;
    assign req_be_o        = commit_head.be;
    assign req_size_o      = commit_head.size;

    // Pointer/count bookkeeping and drain FSM next state
    always_comb begin
        spec_wr_d    = spec_wr_q;
        spec_rd_d    = spec_rd_q;
        spec_cnt_d   = spec_cnt_q + SC_W'(push) - SC_W'(commit);
        commit_wr_d  = commit_wr_q;
        commit_rd_d  = commit_rd_q;
        commit_cnt_d = commit_cnt_q + CC_W'(commit) - CC_W'(pop);
        state_d      = state_q;

        if (push)   spec_wr_d   = spec_wr_q + SP_W'(1);
        if (commit) spec_rd_d   = spec_rd_q + SP_W'(1);
        if (commit) commit_wr_d = commit_wr_q + CP_W'(1);
        if (pop)    commit_rd_d = commit_rd_q + CP_W'(1);
        if (flush_i) begin
            spec_wr_d  = '0;
            spec_rd_d  = '0;
            spec_cnt_d = '0;
        end

        case (state_q)
            IDLE:    if ((commit_cnt_q != '0) && !stall_st_pending_i) state_d = REQ;
            REQ:     if (req_gnt_i)
                         state_d = ((commit_cnt_d != '0) && !stall_st_pending_i) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spec_wr_q    <= '0;
            spec_rd_q    <= '0;
            spec_cnt_q   <= '0;
            commit_wr_q  <= '0;
            commit_rd_q  <= '0;
            commit_cnt_q <= '0;
            state_q      <= IDLE;
        end else begin
            spec_wr_q    <= spec_wr_d;
            spec_rd_q    <= spec_rd_d;
            spec_cnt_q   <= spec_cnt_d;
            commit_wr_q  <= commit_wr_d;
            commit_rd_q  <= commit_rd_d;
            commit_cnt_q <= commit_cnt_d;
            state_q      <= state_d;
        end
    end

    // Payload storage needs no reset: validity lives in the counts
    always_ff @(posedge clk_i) begin
        if (push)   spec_mem_q[spec_wr_q]     <= in_entry;
        if (commit) commit_mem_q[commit_wr_q] <= spec_mem_q[spec_rd_q];
    end

    // Load hazard check over live entries of both queues and the incoming store
    always_comb begin
        page_offset_matches_o = valid_without_flush_i && (paddr_i[11:3] == page_offset_i[11:3]);
        for (int i = 0; i < int'(DEPTH_SPEC); i++) begin
            if ((SC_W'(SP_W'(SP_W'(i) - spec_rd_q)) < spec_cnt_q) &&
                (spec_mem_q[i].addr[8:0] == page_offset_i[11:3]))
                page_offset_matches_o = 1'b1;
        end
        for (int i = 0; i < int'(DEPTH_COMMIT); i++) begin
            if ((CC_W'(CP_W'(CP_W'(i) - commit_rd_q)) < commit_cnt_q) &&
                (commit_mem_q[i].addr[8:0] == page_offset_i[11:3]))
                page_offset_matches_o = 1'b1;
        end
    end

    push_while_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(valid_i && !flush_i && (spec_cnt_q == SPEC_FULL)))
        else $error("store pushed into full speculative queue");

    commit_while_empty_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(commit_i && !flush_i && (spec_cnt_q == '0)))
        else $error("commit with empty speculative queue");

endmodule

// File: tb/tb_store_commit_queue.sv
// Self-checking bench for store_commit_queue: scoreboard of committed stores
// compared against each granted cache request, plus directed status checks.
module tb_store_commit_queue;
    localparam int unsigned PLEN = 56;
    localparam int unsigned XLEN = 64;
    localparam int unsigned BE_W = XLEN / 8;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic            rst_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0, valid_without_flush_i = 1'b0;
    logic            ready_o, commit_i = 1'b0, commit_ready_o, stall_st_pending_i = 1'b0;
    logic            no_st_pending_o, empty_o, page_offset_matches_o, req_valid_o, req_gnt_i = 1'b0;
    logic [PLEN-1:0] paddr_i = '0, req_addr_o;
    logic [XLEN-1:0] data_i = '0, req_data_o;
    logic [BE_W-1:0] be_i = '0, req_be_o;
    logic [1:0]      data_size_i = '0, req_size_o;
    logic [11:0]     page_offset_i = '0;

    store_commit_queue #(.PLEN(PLEN), .XLEN(XLEN), .DEPTH_SPEC(4), .DEPTH_COMMIT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .valid_without_flush_i(valid_without_flush_i), .ready_o(ready_o),
        .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i), .data_size_i(data_size_i),
        .commit_i(commit_i), .commit_ready_o(commit_ready_o),
        .stall_st_pending_i(stall_st_pending_i), .no_st_pending_o(no_st_pending_o),
        .empty_o(empty_o), .page_offset_i(page_offset_i),
        .page_offset_matches_o(page_offset_matches_o), .req_valid_o(req_valid_o),
        .req_gnt_i(req_gnt_i), .req_addr_o(req_addr_o), .req_data_o(req_data_o),
        .req_be_o(req_be_o), .req_size_o(req_size_o)
    );

    typedef struct {
        logic [PLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
        logic [1:0]      size;
    } exp_t;

    exp_t spec_q[$];
    exp_t cm_q[$];
    int   checks = 0;
    int   errors = 0;
    int   grants = 0;

    function automatic exp_t mk(input logic [PLEN-1:0] pa);
        exp_t e;
        e.addr = {pa[PLEN-1:3], 3'b000};
        e.data = {8'hA5, pa};
        e.be   = pa[10:3] | 8'h01;
        e.size = pa[4:3];
        return e;
    endfunction

    task automatic set_in(input logic push, input logic [PLEN-1:0] pa, input logic com,
                          input logic gnt, input logic fl);
        valid_i = push;
        valid_without_flush_i = push;
        paddr_i = pa;
        data_i = {8'hA5, pa};
        be_i = pa[10:3] | 8'h01;
        data_size_i = pa[4:3];
        commit_i = com;
        req_gnt_i = gnt;
        flush_i = fl;
        #1;
    endtask

    // Score the grant, advance the model, clock once, then clear the inputs
    task automatic tick;
        int   nsp, ncm;
        exp_t e;
        logic exp_empty;
        nsp = spec_q.size();
        ncm = cm_q.size();
        if (rst_i) begin
            spec_q.delete();
            cm_q.delete();
        end else begin
            if (req_valid_o && req_gnt_i) begin
                grants++;
                checks++;
                if (cm_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: req_addr_o=%h granted with no committed store", req_addr_o);
                end else begin
                    e = cm_q.pop_front();
                    if (req_addr_o !== e.addr || req_data_o !== e.data || req_be_o !== e.be || req_size_o !== e.size) begin
                        errors++;
                        $display("FAIL grant_payload: got addr=%h data=%h be=%h size=%0d want addr=%h data=%h be=%h size=%0d",
                                 req_addr_o, req_data_o, req_be_o, req_size_o, e.addr, e.data, e.be, e.size);
                    end
                end
            end
            if (flush_i) spec_q.delete();
            else begin
                if (commit_i && nsp > 0 && ncm < 8) cm_q.push_back(spec_q.pop_front());
                if (valid_i && nsp < 4) spec_q.push_back(mk(paddr_i));
            end
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0; valid_without_flush_i = 1'b0; commit_i = 1'b0;
        req_gnt_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0;
        exp_empty = (spec_q.size() == 0) && (cm_q.size() == 0);
        checks++;
        if (empty_o !== exp_empty) begin
            errors++;
            $display("FAIL empty_track: empty_o=%b want %b", empty_o, exp_empty);
        end
    endtask

    task automatic drain_all;
        stall_st_pending_i = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (spec_q.size() == 0 && cm_q.size() == 0 && !req_valid_o) break;
            set_in(1'b0, '0, spec_q.size() > 0, 1'b1, 1'b0);
            tick();
        end
        checks++;
        if (empty_o !== 1'b1 || no_st_pending_o !== 1'b1 || spec_q.size() != 0 || cm_q.size() != 0) begin
            errors++;
            $display("FAIL drain_done: empty_o=%b no_st_pending_o=%b model=%0d/%0d want 1 1 0/0",
                     empty_o, no_st_pending_o, spec_q.size(), cm_q.size());
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; tick();
        rst_i = 1'b1; tick();
        page_offset_i = 12'h000; #1;
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", req_valid_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty_o); end
        checks++; if (no_st_pending_o !== 1'b1) begin errors++; $display("FAIL rst_no_st_pending: got %b want 1", no_st_pending_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready_o); end
        checks++; if (commit_ready_o !== 1'b1) begin errors++; $display("FAIL rst_commit_ready: got %b want 1", commit_ready_o); end
        checks++; if (page_offset_matches_o !== 1'b0) begin errors++; $display("FAIL rst_offset_match: got %b want 0", page_offset_matches_o); end
    endtask

    task automatic test_in_order;
        int g0;
        g0 = grants;
        set_in(1'b1, 56'h1000, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, 56'h1008, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, 56'h1010, 1'b0, 1'b0, 1'b0); tick();
        drain_all();
        checks++;
        if (grants - g0 != 3) begin errors++; $display("FAIL in_order_grants: got %0d want 3", grants - g0); end
    endtask

    task automatic test_full;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 56'h4000 + 56'(8 * k), 1'b0, 1'b0, 1'b0);
            checks++;
            if (ready_o !== (k < 3)) begin errors++; $display("FAIL full_ready_push%0d: got %b want %b", k, ready_o, k < 3); end
            tick();
        end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_idle: got %b want 0", ready_o); end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_commit: got %b want 0", ready_o); end
        tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after_commit: got %b want 1", ready_o); end
        drain_all();
    endtask

    task automatic test_commit_full;
        stall_st_pending_i = 1'b1;
        set_in(1'b1, 56'h5000, 1'b0, 1'b0, 1'b0); tick();
        for (int k = 1; k <= 8; k++) begin
            set_in(1'b1, 56'h5000 + 56'(8 * k), 1'b1, 1'b0, 1'b0); tick();
        end
        checks++; if (commit_ready_o !== 1'b0) begin errors++; $display("FAIL cfull_commit_ready: got %b want 0", commit_ready_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL cfull_ready: got %b want 1", ready_o); end
        stall_st_pending_i = 1'b0;
        tick();
        checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL cfull_req_valid: got %b want 1", req_valid_o); end
        set_in(1'b0, '0, 1'b1, 1'b1, 1'b0); tick();
        checks++; if (commit_ready_o !== 1'b1) begin errors++; $display("FAIL cfull_commit_ready_after_pop: got %b want 1", commit_ready_o); end
        drain_all();
    endtask

    task automatic test_flush;
        int  g0;
        stall_st_pending_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 56'h6000 + 56'(8 * k), 1'b0, 1'b0, 1'b0); tick();
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1); tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", ready_o); end
        checks++; if (no_st_pending_o !== 1'b0) begin errors++; $display("FAIL flush_no_st_pending: got %b want 0", no_st_pending_o); end
        page_offset_i = 12'h010; #1;
        checks++; if (page_offset_matches_o !== 1'b0) begin errors++; $display("FAIL flush_offset_flushed: got %b want 0", page_offset_matches_o); end
        page_offset_i = 12'h008; #1;
        checks++; if (page_offset_matches_o !== 1'b1) begin errors++; $display("FAIL flush_offset_committed: got %b want 1", page_offset_matches_o); end
        page_offset_i = 12'h000;
        stall_st_pending_i = 1'b0;
        g0 = grants;
        for (int k = 0; k < 10; k++) begin
            set_in(1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
            if (grants - g0 == 1) begin
                checks++;
                if (no_st_pending_o !== 1'b0) begin errors++; $display("FAIL flush_no_st_after_1st: got %b want 0", no_st_pending_o); end
            end
            if (grants - g0 == 2) begin
                checks++;
                if (no_st_pending_o !== 1'b1) begin errors++; $display("FAIL flush_no_st_after_2nd: got %b want 1", no_st_pending_o); end
                break;
            end
        end
        checks++; if (grants - g0 != 2) begin errors++; $display("FAIL flush_grants: got %0d want 2", grants - g0); end
    endtask

    task automatic test_offset;
        stall_st_pending_i = 1'b1;
        set_in(1'b1, 56'h2A48, 1'b0, 1'b0, 1'b0); tick();
        page_offset_i = 12'hA4C; #1;
        checks++; if (page_offset_matches_o !== 1'b1) begin errors++; $display("FAIL offset_spec_hit: got %b want 1", page_offset_matches_o); end
        page_offset_i = 12'hA50; #1;
        checks++; if (page_offset_matches_o !== 1'b0) begin errors++; $display("FAIL offset_miss: got %b want 0", page_offset_matches_o); end
        set_in(1'b0, 56'h7A50, 1'b0, 1'b0, 1'b0);
        valid_without_flush_i = 1'b1; #1;
        checks++; if (page_offset_matches_o !== 1'b1) begin errors++; $display("FAIL offset_incoming: got %b want 1", page_offset_matches_o); end
        valid_without_flush_i = 1'b0;
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
        page_offset_i = 12'hA4C; #1;
        checks++; if (page_offset_matches_o !== 1'b1) begin errors++; $display("FAIL offset_commit_hit: got %b want 1", page_offset_matches_o); end
        drain_all();
        checks++; if (page_offset_matches_o !== 1'b0) begin errors++; $display("FAIL offset_after_drain: got %b want 0", page_offset_matches_o); end
        page_offset_i = 12'h000;
    endtask

    task automatic test_stall;
        logic [PLEN-1:0] a;
        logic [XLEN-1:0] d;
        stall_st_pending_i = 1'b1;
        set_in(1'b1, 56'h8000, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, 56'h8008, 1'b1, 1'b0, 1'b0); tick();
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (req_valid_o !== 1'b0) begin errors++; $display("FAIL stall_no_req%0d: got %b want 0", k, req_valid_o); end
        end
        stall_st_pending_i = 1'b0;
        tick();
        checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL stall_release_req: got %b want 1", req_valid_o); end
        checks++; if (req_addr_o !== 56'h8000) begin errors++; $display("FAIL stall_head_addr: got %h want 8000", req_addr_o); end
        a = req_addr_o;
        d = req_data_o;
        for (int k = 0; k < 3; k++) begin
            stall_st_pending_i = (k == 1);
            tick();
            checks++;
            if (req_valid_o !== 1'b1 || req_addr_o !== a || req_data_o !== d) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b addr=%h data=%h want 1 %h %h", k, req_valid_o, req_addr_o, req_data_o, a, d);
            end
        end
        drain_all();
    endtask

    task automatic test_wrap;
        rst_i = 1'b1; tick();
        for (int k = 0; k < 7; k++) begin
            set_in(1'b1, 56'h9000 + 56'(8 * k), 1'b0, 1'b0, 1'b0); tick();
            drain_all();
        end
        set_in(1'b1, 56'hA005, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, 56'hA00B, 1'b1, 1'b0, 1'b0); tick();
        for (int k = 0; k < 5; k++) begin
            if (req_valid_o) break;
            tick();
        end
        checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL wrap_req_timeout: req_valid_o=%b want 1", req_valid_o); end
        set_in(1'b1, 56'hA013, 1'b1, 1'b1, 1'b0); tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b want 1", ready_o); end
        checks++; if (commit_ready_o !== 1'b1) begin errors++; $display("FAIL wrap_commit_ready: got %b want 1", commit_ready_o); end
        checks++; if (req_valid_o !== 1'b1) begin errors++; $display("FAIL wrap_req_valid: got %b want 1", req_valid_o); end
        checks++; if (req_addr_o !== 56'hA008) begin errors++; $display("FAIL wrap_req_addr: got %h want a008", req_addr_o); end
        rst_i = 1'b1; tick();
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_rst_req_valid: got %b want 0", req_valid_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL wrap_rst_empty: got %b want 1", empty_o); end
        checks++; if (no_st_pending_o !== 1'b1) begin errors++; $display("FAIL wrap_rst_no_st: got %b want 1", no_st_pending_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL wrap_rst_ready: got %b want 1", ready_o); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_commit_full();
        test_flush();
        test_offset();
        test_stall();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/store_commit_queue.md
Name: store_commit_queue

Overview:
Downstream consumer of the store unit: accepts translated stores and holds them speculatively until commit. On commit it moves them to an in-order commit queue, which drains to the data cache through a valid/grant request port. It supplies the load unit with a page-offset hazard check and the controller with pending/empty status. Flush discards speculative entries only; committed stores always reach memory.

Parameters:
PLEN, 56, physical address width
XLEN, 64, data width (32 or 64)
DEPTH_SPEC, 4, speculative queue entries (power of 2, >=2)
DEPTH_COMMIT, 8, commit queue entries (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  discard speculative entries
valid_i  in  1  push store (already flush-gated by the producer)
valid_without_flush_i  in  1  push qualifier used only for the offset check
ready_o  out  1  space available for a push next cycle
paddr_i  in  PLEN  store physical address
data_i  in  XLEN  aligned store data
be_i  in  XLEN/8  byte enables
data_size_i  in  2  log2 transfer size
commit_i  in  1  commit oldest speculative store
commit_ready_o  out  1  commit queue can accept
stall_st_pending_i  in  1  block new cache requests
no_st_pending_o  out  1  commit queue empty and no request in flight
empty_o  out  1  both queues empty
page_offset_i  in  12  load address offset to check
page_offset_matches_o  out  1  offset hazard with a buffered or incoming store
req_valid_o  out  1  cache write request
req_gnt_i  in  1  cache grant
req_addr_o  out  PLEN  request address, doubleword aligned (low 3 bits zero)
req_data_o  out  XLEN  request data
req_be_o  out  XLEN/8  request byte enables
req_size_o  out  2  request size

Behaviour:
- Reset (rst_i high at a clock edge) clears all pointers and counters, and any speculative or committed content is lost; a reset mid-drain drops the request.
- Reset output values: req_valid_o=0; empty_o=1; no_st_pending_o=1; ready_o=1; commit_ready_o=1; page_offset_matches_o=0.
- Speculative queue is a circular FIFO with pointers that wrap at DEPTH_SPEC and a count of 0..DEPTH_SPEC.
  - Push when valid_i.
  - ready_o = (spec_cnt + valid_i) < DEPTH_SPEC. This accounts for a push in the current cycle, because the producer samples ready_o one cycle before it posts.
  - Pushing while full is an error, covered by an assertion; the entry is dropped.
- Commit:
  - When commit_i && commit_ready_o && spec_cnt>0, the head of the speculative queue moves into the commit queue in the same cycle.
  - commit_ready_o = commit_cnt < DEPTH_COMMIT (combinational from the count; it ignores the same-cycle pop).
  - commit_i while spec is empty is an assertion error and is ignored.
- Flush: spec_cnt and both spec pointers reset at the next edge.
  - A push or commit in the flush cycle is discarded.
  - The commit queue is unaffected.
- Drain FSM has 2 states:
  - IDLE: go to REQ when commit_cnt>0 and !stall_st_pending_i.
  - REQ: req_valid_o=1, and req_* hold the commit head stable until grant. On req_gnt_i, pop the head; stay in REQ if another entry exists and there is no stall, else go to IDLE.
  - stall_st_pending_i never withdraws a raised request.
- Request fields: req_addr_o = {paddr[PLEN-1:3],3'b0}; req_data_o, req_be_o and req_size_o come from the head entry.
- Simultaneous events: push, commit and pop in one cycle are all honoured, and counts update by net change. Commit and pop in one cycle while the commit queue is full is legal.
- no_st_pending_o = (commit_cnt==0) && state==IDLE.
- empty_o = (spec_cnt==0) && (commit_cnt==0).
- page_offset_matches_o is combinational. It is 1 if page_offset_i[11:3] equals paddr[11:3] of any valid entry in either queue, or of the incoming store when valid_without_flush_i.
- All other outputs are registered or derived from counts; there is no combinational path from req_gnt_i to ready_o.

Test Plan:
- Reset, push 3 stores (paddr 0x1000/0x1008/0x1010), commit all, grant every cycle → req_addr_o 0x1000, 0x1008, 0x1010 in order; empty_o=1 after the 3rd grant.
- DEPTH_SPEC=4: push 4 with no commit → ready_o=0 in the 4th push cycle; commit 1 → ready_o=1 in the next cycle.
- 2 committed and 2 speculative stores, flush_i pulse → spec_cnt=0, both committed stores still drain, and no_st_pending_o rises after the 2nd grant.
- Entry at paddr 0x2A48, page_offset_i=0xA4C → page_offset_matches_o=1; page_offset_i=0xA50 → 0; incoming store 0xA50 with valid_without_flush_i=1 → 1.
- stall_st_pending_i=1 with 2 committed → req_valid_o stays 0; deassert the stall → request issues the next cycle; request held 3 cycles without grant → req_* stable.
- Push, commit and grant in the same cycle at wrap-around (pointers at DEPTH-1) → counts correct; assert rst_i mid-request → req_valid_o=0 and empty_o=1 the next cycle.
